// File: rtl/axi_mem_pkg.sv
// Shared types and helpers for the AXI4 memory responder.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // Write response code; the responder never reports anything else.
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Ceiling log2, used for WORD_BYTE and MEM_DEPTH bit counts.
    function automatic int log2c(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_mem_if.sv
// AXI4 AW/W/B/AR/R channel bundle between a kernel master and the memory responder.
interface axi_mem_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64
);
    localparam int WORD_BYTE = DATA_WIDTH / 8;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [WORD_BYTE-1:0]  wstrb;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;

    modport master (
        output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arlen, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arlen, rready,
        output awready, wready, bvalid, arready, rvalid, rdata, rlast
    );

endinterface

// File: rtl/axi_mem_ram.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
// A same-address read and write in one cycle returns the old word (read-first).
module axi_mem_ram
    import axi_mem_pkg::*;
#(
    parameter int  DATA_WIDTH = 512,
    parameter int  MEM_DEPTH  = 1024,
    localparam int WORD_BYTE  = DATA_WIDTH / 8,
    localparam int AW         = log2c(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [WORD_BYTE-1:0]  wstrb,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Byte-masked write; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < WORD_BYTE; b++) begin
            if (we && wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    // Output register only advances on a read, so it holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 memory-side responder: INCR read and write bursts served from an on-chip RAM.
// Read and write FSMs are independent and may run at the same time.
// Optional macro AXI_MEM_RESP_PROTO_CHECK_EN adds a sticky proto_err output
// flagging wlast misplacement and bursts that wrap the RAM.
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic     aclk,
    input  logic     areset,
    axi_mem_if.slave s_axi
`ifdef AXI_MEM_RESP_PROTO_CHECK_EN
    ,
    output logic     proto_err
`endif
);
    localparam int WB_LOG = log2c(DATA_WIDTH / 8);
    localparam int IDX_W  = log2c(MEM_DEPTH);

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;
    logic [IDX_W-1:0]      w_idx_q, r_idx_q;
    logic [7:0]            w_left_q;     // beats remaining after the current one
    logic [8:0]            r_left_q;     // RAM reads not yet issued
    logic                  rvalid_q, rlast_q;
    logic [IDX_W-1:0]      aw_idx, ar_idx;
    logic                  aw_hs, w_hs, ar_hs, r_issue;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Low byte-lane bits and bits above the RAM index are dropped, so addresses alias.
    assign aw_idx = s_axi.awaddr[WB_LOG +: IDX_W];
    assign ar_idx = s_axi.araddr[WB_LOG +: IDX_W];

    // Handshakes derived from state so ready->valid paths stay out of the comb loop.
    assign aw_hs = s_axi.awvalid && (w_state_q == W_IDLE);
    assign w_hs  = s_axi.wvalid  && (w_state_q == W_DATA);
    assign ar_hs = s_axi.arvalid && (r_state_q == R_IDLE);

    // A new read is issued when the output slot is empty or being drained this cycle.
    assign r_issue = (r_state_q == R_DATA) && (r_left_q != 9'd0) && (!rvalid_q || s_axi.rready);

    // Write FSM state register.
    always_ff @(posedge aclk) begin
        if (areset) w_state_q <= W_IDLE;
        else        w_state_q <= w_state_d;
    end

    // Write FSM next state and channel readies; wlast plays no part in burst length.
    always_comb begin
        w_state_d     = w_state_q;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                s_axi.awready = 1'b1;
                if (s_axi.awvalid) w_state_d = W_DATA;
            end
            W_DATA: begin
                s_axi.wready = 1'b1;
                if (s_axi.wvalid && (w_left_q == 8'd0)) w_state_d = W_RESP;
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write burst pointer and beat countdown.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_idx_q  <= '0;
            w_left_q <= '0;
        end else if (aw_hs) begin
            w_idx_q  <= aw_idx;
            w_left_q <= s_axi.awlen;
        end else if (w_hs) begin
            w_idx_q  <= w_idx_q + IDX_W'(1);
            w_left_q <= w_left_q - 8'd1;
        end
    end

    // Read FSM state register.
    always_ff @(posedge aclk) begin
        if (areset) r_state_q <= R_IDLE;
        else        r_state_q <= r_state_d;
    end

    // Read FSM next state; the burst ends when the rlast beat is accepted.
    always_comb begin
        r_state_d     = r_state_q;
        s_axi.arready = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                s_axi.arready = 1'b1;
                if (s_axi.arvalid) r_state_d = R_DATA;
            end
            R_DATA: begin
                if (rvalid_q && s_axi.rready && rlast_q) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read pointer, issue countdown and the rvalid/rlast slot that tracks the RAM output register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_idx_q  <= '0;
            r_left_q <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_idx_q  <= ar_idx;
                r_left_q <= {1'b0, s_axi.arlen} + 9'd1;
            end else if (r_issue) begin
                r_idx_q  <= r_idx_q + IDX_W'(1);
                r_left_q <= r_left_q - 9'd1;
            end
            if (r_issue) begin
                rvalid_q <= 1'b1;
                rlast_q  <= (r_left_q == 9'd1);
            end else if (s_axi.rready) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    assign s_axi.rvalid = rvalid_q;
    assign s_axi.rlast  = rlast_q;
    assign s_axi.rdata  = ram_rdata;

    axi_mem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk   (aclk),
        .rst   (areset),
        .we    (w_hs && !areset),
        .waddr (w_idx_q),
        .wdata (s_axi.wdata),
        .wstrb (s_axi.wstrb),
        .re    (r_issue),
        .raddr (r_idx_q),
        .rdata (ram_rdata)
    );

`ifdef AXI_MEM_RESP_PROTO_CHECK_EN
    // Sticky protocol flag: wlast in the wrong place, or a burst that runs off the top of the RAM.
    always_ff @(posedge aclk) begin
        if (areset) begin
            proto_err <= 1'b0;
        end else if ((w_hs && (s_axi.wlast != (w_left_q == 8'd0))) ||
                     (aw_hs && (int'(aw_idx) + int'(s_axi.awlen) >= MEM_DEPTH)) ||
                     (ar_hs && (int'(ar_idx) + int'(s_axi.arlen) >= MEM_DEPTH))) begin
            proto_err <= 1'b1;
        end
    end
`endif

    // Address bits outside the index and (without the checker) wlast are intentionally ignored;
    // the response code is fixed, so it is not driven anywhere.
    logic unused_ok;
    assign unused_ok = ^{s_axi.awaddr[ADDR_WIDTH-1:0], s_axi.araddr[ADDR_WIDTH-1:0],
                         s_axi.wlast, RESP_OKAY};

endmodule
